// File: rtl/speed_stats.sv
// rtl/speed_stats.sv - running max/min/average statistics over a speed sample stream
//
// Purpose: tracks the largest accepted sample, the smallest accepted nonzero
// sample, and the truncated mean of the counted (nonzero) samples. The mean is
// computed by a one-bit-per-cycle restoring divider that runs in the
// background; requests arriving while it is busy coalesce into one pending
// division.
//
// Ports:
//   clk          single clock, rising edge
//   r            synchronous active-high reset
//   sample_valid qualifies speed for one cycle
//   speed        unsigned speed sample (WIDTH bits)
//   pause        when high, samples are ignored (running division continues)
//   max_out      largest accepted sample
//   min_out      smallest accepted nonzero sample
//   avg_out      truncated mean of counted samples, saturated to WIDTH bits
//   avg_valid    one-cycle pulse when avg_out is updated
//   count_out    number of counted samples (saturates at all ones)
//   overflow     sticky flag, set when a sample arrives with the counter full

module speed_stats #(
  parameter int WIDTH     = 12,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     speed,
  input  logic                 pause,
  output logic [WIDTH-1:0]     max_out,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     avg_out,
  output logic                 avg_valid,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 overflow
);

  localparam int ACC_WIDTH = WIDTH + CNT_WIDTH;
  localparam int BW        = $clog2(ACC_WIDTH);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [BW-1:0]        LAST_BIT = BW'(ACC_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   pend;

  // Divider datapath: dvd starts as the dividend and shifts quotient bits in
  // from the right, so after ACC_WIDTH steps it holds the quotient.
  logic [ACC_WIDTH-1:0]   dvd;
  logic [CNT_WIDTH-1:0]   dvs;
  logic [CNT_WIDTH-1:0]   rem;
  logic [BW-1:0]          bit_cnt;

  logic                   accept;
  logic                   nonzero;
  logic                   raise;
  logic                   consume;
  logic [CNT_WIDTH:0]     trial;
  logic [CNT_WIDTH:0]     diff;
  logic                   ge;
  logic [WIDTH-1:0]       quot_sat;

  always_comb begin
    accept  = sample_valid && !pause;
    nonzero = (speed != '0);
    raise   = accept && nonzero && (count_out != CNT_MAX);
    // A pending request is taken either from IDLE or straight out of DONE.
    consume = pend && ((state == IDLE) || (state == DONE));

    // Remainder is always below the divisor, so CNT_WIDTH+1 bits hold a trial.
    trial = {rem, dvd[ACC_WIDTH-1]};
    ge    = (trial >= {1'b0, dvs});
    diff  = trial - {1'b0, dvs};

    if (|dvd[ACC_WIDTH-1:WIDTH]) quot_sat = {WIDTH{1'b1}};
    else                         quot_sat = dvd[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (r) begin
      max_out   <= '0;
      min_out   <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
      sum       <= '0;
      pend      <= 1'b0;
      state     <= IDLE;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      bit_cnt   <= '0;
    end else begin
      avg_valid <= 1'b0;

      if (accept) begin
        if (speed > max_out) max_out <= speed;
        if (nonzero) begin
          if ((count_out == '0) || (speed < min_out)) min_out <= speed;
          if (count_out != CNT_MAX) begin
            sum       <= sum + ACC_WIDTH'(speed);
            count_out <= count_out + CNT_WIDTH'(1);
          end else begin
            overflow <= 1'b1;
          end
        end
      end

      pend <= raise || (pend && !consume);

      // Snapshot uses the registered sum/count from before this edge.
      if (consume) begin
        dvd     <= sum;
        dvs     <= count_out;
        rem     <= '0;
        bit_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (pend) state <= DIV;
        end
        DIV: begin
          rem     <= ge ? diff[CNT_WIDTH-1:0] : trial[CNT_WIDTH-1:0];
          dvd     <= {dvd[ACC_WIDTH-2:0], ge};
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == LAST_BIT) state <= DONE;
        end
        DONE: begin
          avg_out   <= quot_sat;
          avg_valid <= 1'b1;
          state     <= pend ? DIV : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speed_stats.sv
// tb/tb_speed_stats.sv - directed self-checking bench for speed_stats

module tb_speed_stats;

  logic        clk = 1'b0;
  logic        r = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] speed = '0;
  logic        pause = 1'b0;
  logic [11:0] max_out, min_out, avg_out;
  logic        avg_valid;
  logic [15:0] count_out;
  logic        overflow;

  logic        r2 = 1'b1;
  logic        v2 = 1'b0;
  logic [11:0] s2 = '0;
  logic        p2 = 1'b0;
  logic [11:0] max2, min2, avg2;
  logic        avgv2;
  logic [3:0]  cnt2;
  logic        ovf2;

  speed_stats dut (
    .clk(clk), .r(r), .sample_valid(sample_valid), .speed(speed), .pause(pause),
    .max_out(max_out), .min_out(min_out), .avg_out(avg_out), .avg_valid(avg_valid),
    .count_out(count_out), .overflow(overflow)
  );

  speed_stats #(.WIDTH(12), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .r(r2), .sample_valid(v2), .speed(s2), .pause(p2),
    .max_out(max2), .min_out(min2), .avg_out(avg2), .avg_valid(avgv2),
    .count_out(cnt2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          npulse = 0;
  logic [11:0] pval [0:63];
  int          pcyc [0:63];
  always @(negedge clk) begin
    if (avg_valid) begin
      if (npulse < 64) begin
        pval[npulse] = avg_out;
        pcyc[npulse] = cyc;
      end
      npulse = npulse + 1;
    end
  end

  int n_checks = 0;
  int n_err = 0;
  int acc_cyc = 0;
  int base = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [11:0] v);
    sample_valid = 1'b1;
    speed = v;
    acc_cyc = cyc + 1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send2(input logic [11:0] v);
    v2 = 1'b1;
    s2 = v;
    @(negedge clk);
    v2 = 1'b0;
  endtask

  initial begin
    idle(3);
    check("rst_max", max_out, 0);
    check("rst_min", min_out, 0);
    check("rst_avg", avg_out, 0);
    check("rst_cnt", count_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_avgv", avg_valid, 0);
    r = 1'b0;
    r2 = 1'b0;
    idle(2);

    // 100, 300, 200 spaced 40 cycles: averages 100, 200, 200
    base = npulse;
    send(100);
    idle(39);
    check("lat_first", pcyc[base] - acc_cyc, 30);
    check("avg1", pval[base], 100);
    send(300); idle(39);
    send(200); idle(39);
    check("p3_count", npulse - base, 3);
    check("avg2", pval[base+1], 200);
    check("avg3", pval[base+2], 200);
    check("max_a", max_out, 300);
    check("min_a", min_out, 100);
    check("cnt_a", count_out, 3);
    check("avgout_a", avg_out, 200);

    // zero sample: no effect on min/count, no division
    base = npulse;
    send(0); idle(40);
    check("zero_max", max_out, 300);
    check("zero_min", min_out, 100);
    check("zero_cnt", count_out, 3);
    check("zero_pulse", npulse - base, 0);

    // paused sample is ignored
    pause = 1'b1;
    send(4000); idle(40);
    pause = 1'b0;
    check("pause_max", max_out, 300);
    check("pause_cnt", count_out, 3);
    check("pause_avg", avg_out, 200);
    check("pause_pulse", npulse - base, 0);

    // back-to-back samples coalesce into two divisions
    r = 1'b1; idle(1); r = 1'b0; idle(1);
    base = npulse;
    send(10); send(20); send(30);
    idle(90);
    check("b2b_pulses", npulse - base, 2);
    check("b2b_avg1", pval[base], 10);
    check("b2b_avg2", pval[base+1], 20);
    check("b2b_cnt", count_out, 3);
    check("b2b_max", max_out, 30);
    check("b2b_min", min_out, 10);

    // reset mid-division, with a simultaneous sample that must lose
    send(100);
    idle(10);
    r = 1'b1; sample_valid = 1'b1; speed = 500;
    base = npulse;
    @(negedge clk);
    r = 1'b0; sample_valid = 1'b0;
    check("abort_max", max_out, 0);
    check("abort_min", min_out, 0);
    check("abort_avg", avg_out, 0);
    check("abort_cnt", count_out, 0);
    idle(50);
    check("abort_pulse", npulse - base, 0);

    // counter saturation on the 4-bit counter build
    for (int i = 0; i < 15; i++) send2(50);
    check("sat15_cnt", cnt2, 15);
    check("sat15_ovf", ovf2, 0);
    send2(50);
    check("sat16_ovf", ovf2, 1);
    send2(60);
    idle(100);
    check("sat_cnt", cnt2, 15);
    check("sat_ovf", ovf2, 1);
    check("sat_avg", avg2, 50);
    check("sat_max", max2, 60);
    check("sat_min", min2, 50);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/speed_stats.md
SPEED_STATS -- requirements
Module: speed_stats

Interface
REQ-001 Parameter WIDTH, default 12, SHALL set the speed sample width and the width of max_out, min_out and avg_out.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of the accepted-sample counter; the accumulator width ACC_WIDTH SHALL be derived as WIDTH+CNT_WIDTH and SHALL NOT be a parameter.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 r  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 sample_valid  input  1  SHALL qualify speed for one cycle.
REQ-006 speed  input  WIDTH  SHALL carry the unsigned speed sample.
REQ-007 pause  input  1  SHALL, when high, cause every sample to be ignored.
REQ-008 max_out  output  WIDTH  SHALL be the largest accepted sample.
REQ-009 min_out  output  WIDTH  SHALL be the smallest accepted nonzero sample.
REQ-010 avg_out  output  WIDTH  SHALL be the truncated mean of the counted samples.
REQ-011 avg_valid  output  1  SHALL be a one-cycle pulse marking an avg_out update.
REQ-012 count_out  output  CNT_WIDTH  SHALL be the number of counted samples.
REQ-013 overflow  output  1  SHALL be the sticky flag for counter saturation.

Function
REQ-014 A sample SHALL be accepted on any edge where sample_valid=1, pause=0 and r=0.
REQ-015 On acceptance, max_out SHALL become speed if speed > max_out; otherwise it SHALL hold.
REQ-016 A sample with speed=0 SHALL update only max_out (no effect there) and SHALL NOT affect min_out, sum, count_out or the divider.
REQ-017 On acceptance of a nonzero sample, min_out SHALL become speed if count_out=0 or speed < min_out.
REQ-018 On acceptance of a nonzero sample with count_out < 2^CNT_WIDTH-1:
- the ACC_WIDTH-bit sum SHALL add speed;
- count_out SHALL increment;
- a division request SHALL be raised.
REQ-019 On acceptance of a nonzero sample with count_out = 2^CNT_WIDTH-1:
- sum and count_out SHALL hold;
- overflow SHALL set and stay set until reset;
- max_out and min_out SHALL still update.
REQ-020 Divider FSM states SHALL be IDLE, DIV and DONE.
REQ-021 IDLE -> DIV SHALL occur on the edge after a request is raised, or immediately on leaving DONE when a request is pending; entry SHALL snapshot the registered sum and count_out values present before that edge.
REQ-022 DIV SHALL run a restoring divide producing one quotient bit per cycle for exactly ACC_WIDTH cycles, then transition to DONE.
REQ-023 In DONE, avg_out SHALL load the quotient, saturated to 2^WIDTH-1; avg_valid SHALL be 1 for that single cycle; the FSM SHALL then go to IDLE, or to DIV if a request is pending.
REQ-024 Requests raised while in DIV or DONE SHALL coalesce into one pending flag; the next division SHALL use the snapshot taken at its own DIV entry.
REQ-025 For an isolated request raised at edge k, avg_out and avg_valid SHALL update at edge k+ACC_WIDTH+2 (k+30 at defaults).
REQ-026 pause SHALL NOT stop an in-progress division.

Reset
REQ-027 While r=1, max_out, min_out, avg_out, count_out, sum, overflow, avg_valid and the pending flag SHALL be 0, and the FSM SHALL be IDLE.
REQ-028 Reset during DIV or DONE SHALL abort the division, with no avg_valid pulse, and r SHALL take priority over a simultaneous sample.

Verification
REQ-029 Reset; samples 100, 300, 200 spaced 40 cycles -> max_out=300, min_out=100, count_out=3, final avg_out=200, three avg_valid pulses.
REQ-030 After REQ-029, sample 0 -> max_out=300, min_out=100, count_out=3 unchanged, no avg_valid pulse.
REQ-031 pause=1 with sample 4000 -> all outputs unchanged, no avg_valid pulse.
REQ-032 Reset; samples 10, 20, 30 on consecutive cycles -> first avg_valid shows avg_out=10, second shows avg_out=20, exactly two pulses, count_out=3.
REQ-033 CNT_WIDTH=4 build; sixteen samples of 50 then one of 60 -> count_out=15, overflow=1, avg_out=50, max_out=60, min_out=50.
REQ-034 Reset asserted mid-DIV -> all outputs 0 on the next edge, no avg_valid pulse afterwards without new samples.
